mips_decode_stage: RTL
======================

MIPS_DECODE_STAGE -- requirements
Module: mips_decode_stage

Interface
REQ-001 SHALL have parameter PC_W, default 32: program-counter width carried alongside each instruction.
REQ-002 SHALL have parameter CNT_W, default 32: width of each statistics counter.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: fetch presents an instruction.
REQ-006 SHALL have port in_ready, output, 1: decoder accepts this cycle.
REQ-007 SHALL have port in_instr, input, 32: raw instruction word.
REQ-008 SHALL have port in_pc, input, PC_W: PC of in_instr.
REQ-009 SHALL have port flush, input, 1: discard held and incoming instruction.
REQ-010 SHALL have port out_valid, output, 1: decoded bundle valid.
REQ-011 SHALL have port out_ready, input, 1: execute stage consumes.
REQ-012 SHALL have port out_op, output, 6: operation_t opcode.
REQ-013 SHALL have ports out_rs, out_rt and out_rd, output, 5 each: register fields.
REQ-014 SHALL have port out_imm, output, 32: extended immediate.
REQ-015 SHALL have port out_pc, output, PC_W: PC of the bundle.
REQ-016 SHALL have port out_illegal, output, 1: opcode is not in operation_t.
REQ-017 SHALL have port halted, output, 1: HALT has been accepted.
REQ-018 SHALL have ports stat_inst, stat_arith, stat_log, stat_mem and stat_ctrl, output, CNT_W each: instruction-class counters (present only when the stats macro is defined).

Function
REQ-019 SHALL decode fields as: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0].
REQ-020 SHALL register all outputs: one cycle of latency from input acceptance to out_valid.
REQ-021 SHALL accept an input when in_valid && in_ready; SHALL drive in_ready = !halted && !flush && (!out_valid || out_ready).
REQ-022 SHALL hold every out_* field stable while out_valid && !out_ready.
REQ-023 SHALL sign-extend imm for ADDI, SUBI, MULI, LDW, STW, BZ and BEQ; SHALL zero-extend imm for ORI, ANDI and XORI; SHALL drive out_imm to 0 for all other opcodes.
REQ-024 SHALL drive out_rd = instr[15:11] for ADD, SUB, MUL, OR, AND and XOR; SHALL drive out_rd = 0 otherwise.
REQ-025 SHALL, for an illegal opcode, drive out_op = NOP with out_illegal = 1, and SHALL still pass the bundle downstream.
REQ-026 SHALL implement an FSM with states RUN and HALTED; RUN->HALTED on the edge that accepts HALT; HALTED is left only by reset.
REQ-027 SHALL emit the HALT bundle downstream normally, and SHALL assert halted from the cycle after HALT is accepted.
REQ-028 SHALL clear out_valid on the next edge when flush = 1 (flush wins over a simultaneous accept or hold); flush SHALL NOT change FSM state.
REQ-029 SHALL, on simultaneous out_ready and a new accept, replace the bundle back-to-back (full throughput, no bubble).

Reset
REQ-030 SHALL, on reset, drive out_valid=0, out_op=NOP, out_rs/rt/rd=0, out_imm=0, out_pc=0, out_illegal=0, halted=0, FSM=RUN, and all counters=0.
REQ-031 SHALL let reset mid-stall or in HALTED override everything, with in_ready=0 during the reset cycle.

Configuration
REQ-032 SHALL, with macro MIPS_DECODE_STATS_EN defined, increment counters on each accepted, non-flushed input: stat_inst always; arith for ADD..MULI; log for OR..XORI; mem for LDW/STW; ctrl for BZ/BEQ/JR/HALT; NOP and illegal opcodes count in stat_inst only.
REQ-033 SHALL saturate every counter at all-ones.
REQ-034 SHALL, without MIPS_DECODE_STATS_EN, omit the counter ports and counter logic entirely.

Structure
REQ-035 SHALL take operation_t, op_width, reg_width, imm_width and instr_width from the shared mips_defs package; SHALL add a decode-state enum (RUN, HALTED) and an op-class enum there.
REQ-036 SHALL place the opcode classification and immediate extension in sub-module mips_op_classify (purely combinational); all state SHALL live in mips_decode_stage.

Verification
REQ-037 SHALL verify: in_instr 0x0401FFFC (ADDI) with out_ready=1 -> next cycle out_op=ADDI, rs=0, rt=1, out_imm=0xFFFFFFFC.
REQ-038 SHALL verify: in_instr 0x1C228000 (ORI) -> out_imm=0x00008000, rs=1, rt=2, out_rd=0.
REQ-039 SHALL verify: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_* stable; releasing out_ready -> the next instruction appears one cycle later.
REQ-040 SHALL verify: in_instr 0xC0000000 -> out_op=NOP, out_illegal=1, stat_inst +1, other counters unchanged.
REQ-041 SHALL verify: 0x44000000 (HALT) accepted -> HALT bundle emitted, halted=1 the following cycle, in_ready stays 0 until reset.
REQ-042 SHALL verify: flush asserted while out_valid=1 and out_ready=0 -> out_valid=0 next cycle and no counter increments for the flushed input.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS definitions: opcode encoding, field widths, decode FSM state
// and instruction-class enums used by the decode stage.
package mips_defs;

    localparam int op_width    = 6;
    localparam int reg_width   = 5;
    localparam int imm_width   = 16;
    localparam int instr_width = 32;

    typedef enum logic [op_width-1:0] {
        ADD  = 6'd0,
        ADDI = 6'd1,
        SUB  = 6'd2,
        SUBI = 6'd3,
        MUL  = 6'd4,
        MULI = 6'd5,
        OR   = 6'd6,
        ORI  = 6'd7,
        AND  = 6'd8,
        ANDI = 6'd9,
        XOR  = 6'd10,
        XORI = 6'd11,
        LDW  = 6'd12,
        STW  = 6'd13,
        BZ   = 6'd14,
        BEQ  = 6'd15,
        JR   = 6'd16,
        HALT = 6'd17,
        NOP  = 6'd18
    } operation_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } decode_state_t;

    // Numeric values double as counter indices in the decode stage (1..4).
    typedef enum logic [2:0] {
        CLS_NONE  = 3'd0,
        CLS_ARITH = 3'd1,
        CLS_LOG   = 3'd2,
        CLS_MEM   = 3'd3,
        CLS_CTRL  = 3'd4
    } op_class_t;

endpackage

// File: rtl/mips_op_classify.sv
// Combinational opcode classification: legal-op check, class, immediate
// extension and whether the rd field is meaningful.
module mips_op_classify
    import mips_defs::*;
(
    input  logic [op_width-1:0]    opcode_i,
    input  logic [imm_width-1:0]   imm_i,
    output operation_t             op_o,
    output op_class_t              cls_o,
    output logic [instr_width-1:0] imm_ext_o,
    output logic                   rd_used_o,
    output logic                   illegal_o
);

    logic [instr_width-1:0] imm_sext;
    logic [instr_width-1:0] imm_zext;

    assign imm_sext = {{(instr_width-imm_width){imm_i[imm_width-1]}}, imm_i};
    assign imm_zext = {{(instr_width-imm_width){1'b0}}, imm_i};

    always_comb begin
        op_o      = NOP;
        cls_o     = CLS_NONE;
        imm_ext_o = '0;
        rd_used_o = 1'b0;
        illegal_o = 1'b0;
        case (opcode_i)
            ADD, SUB, MUL: begin
                op_o      = operation_t'(opcode_i);
                cls_o     = CLS_ARITH;
                rd_used_o = 1'b1;
            end
            ADDI, SUBI, MULI: begin
                op_o      = operation_t'(opcode_i);
                cls_o     = CLS_ARITH;
                imm_ext_o = imm_sext;
            end
            OR, AND, XOR: begin
                op_o      = operation_t'(opcode_i);
                cls_o     = CLS_LOG;
                rd_used_o = 1'b1;
            end
            ORI, ANDI, XORI: begin
                op_o      = operation_t'(opcode_i);
                cls_o     = CLS_LOG;
                imm_ext_o = imm_zext;
            end
            LDW, STW: begin
                op_o      = operation_t'(opcode_i);
                cls_o     = CLS_MEM;
                imm_ext_o = imm_sext;
            end
            BZ, BEQ: begin
                op_o      = operation_t'(opcode_i);
                cls_o     = CLS_CTRL;
                imm_ext_o = imm_sext;
            end
            JR, HALT: begin
                op_o  = operation_t'(opcode_i);
                cls_o = CLS_CTRL;
            end
            NOP: op_o = NOP;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_decode_stage.sv
// Registered MIPS decode stage with valid/ready handshake, flush and HALT.
// Instruction-class counters are built only with MIPS_DECODE_STATS_EN.
//
// state  | meaning
// RUN    | accepting and decoding instructions
// HALTED | HALT accepted; input closed until reset
module mips_decode_stage
    import mips_defs::*;
#(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [instr_width-1:0] in_instr,
    input  logic [PC_W-1:0]        in_pc,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [op_width-1:0]    out_op,
    output logic [reg_width-1:0]   out_rs,
    output logic [reg_width-1:0]   out_rt,
    output logic [reg_width-1:0]   out_rd,
    output logic [instr_width-1:0] out_imm,
    output logic [PC_W-1:0]        out_pc,
    output logic                   out_illegal,
    output logic                   halted
`ifdef MIPS_DECODE_STATS_EN
    ,
    output logic [CNT_W-1:0]       stat_inst,
    output logic [CNT_W-1:0]       stat_arith,
    output logic [CNT_W-1:0]       stat_log,
    output logic [CNT_W-1:0]       stat_mem,
    output logic [CNT_W-1:0]       stat_ctrl
`endif
);

    decode_state_t          state_q, state_d;
    logic                   valid_q, valid_d;
    operation_t             op_q, op_d;
    logic [reg_width-1:0]   rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [instr_width-1:0] imm_q, imm_d;
    logic [PC_W-1:0]        pc_q, pc_d;
    logic                   illegal_q, illegal_d;

    operation_t             dec_op;
    op_class_t              dec_cls;
    logic [instr_width-1:0] dec_imm;
    logic                   dec_rd_used;
    logic                   dec_illegal;
    logic                   accept;

    mips_op_classify u_classify (
        .opcode_i  (in_instr[31:26]),
        .imm_i     (in_instr[15:0]),
        .op_o      (dec_op),
        .cls_o     (dec_cls),
        .imm_ext_o (dec_imm),
        .rd_used_o (dec_rd_used),
        .illegal_o (dec_illegal)
    );

    // Reset is folded in so upstream never sees a handshake during reset.
    assign in_ready = !reset && (state_q == RUN) && !flush && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        op_d      = op_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        imm_d     = imm_q;
        pc_d      = pc_q;
        illegal_d = illegal_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d   = 1'b1;
            op_d      = dec_op;
            rs_d      = in_instr[25:21];
            rt_d      = in_instr[20:16];
            rd_d      = dec_rd_used ? in_instr[15:11] : '0;
            imm_d     = dec_imm;
            pc_d      = in_pc;
            illegal_d = dec_illegal;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        if ((state_q == RUN) && accept && (dec_op == HALT)) begin
            state_d = HALTED;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            valid_q   <= 1'b0;
            op_q      <= NOP;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            op_q      <= op_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            imm_q     <= imm_d;
            pc_q      <= pc_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_op      = op_q;
    assign out_rs      = rs_q;
    assign out_rt      = rt_q;
    assign out_rd      = rd_q;
    assign out_imm     = imm_q;
    assign out_pc      = pc_q;
    assign out_illegal = illegal_q;
    assign halted      = (state_q == HALTED);

`ifdef MIPS_DECODE_STATS_EN
    // Index 0 counts every accepted instruction; 1..4 follow op_class_t.
    logic [CNT_W-1:0] cnt_q [5];
    logic [CNT_W-1:0] cnt_d [5];

    always_comb begin
        for (int k = 0; k < 5; k++) begin
            cnt_d[k] = cnt_q[k];
            if (accept && ((k == 0) || (int'(dec_cls) == k)) && (cnt_q[k] != '1)) begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 5; k++) begin
            if (reset) begin
                cnt_q[k] <= '0;
            end else begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign stat_inst  = cnt_q[0];
    assign stat_arith = cnt_q[1];
    assign stat_log   = cnt_q[2];
    assign stat_mem   = cnt_q[3];
    assign stat_ctrl  = cnt_q[4];
`else
    // Keeps CNT_W referenced when the counters are compiled out.
    logic [CNT_W-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif

endmodule
